sdram_port_arbiter: RTL and testbench

Two-port arbiter that shares the single SDRAM controller command/response port inside the Pinsec SoC between the CPU data-bus bridge (port 0) and the video frame-fetch DMA (port 1). It selects one requester per command beat and holds the grant across multi-beat bursts. It routes in-order read responses back to the issuing port and prevents port 0 starvation with a wait counter. It sits between the two bus masters and the SDRAM controller, all on `io_axiClk`.

---
 rtl/sdram_arb_pkg.sv | 21 ++
 rtl/sdram_arb_id_fifo.sv | 52 +++++
 rtl/sdram_port_arbiter.sv | 137 +++++++++++++
 tb/tb_sdram_port_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM command arbiter.
// Used by the top level and its response-ID FIFO.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_t;

  localparam logic PORT_CPU   = 1'b0;
  localparam logic PORT_VIDEO = 1'b1;

  localparam int unsigned DEF_ADDR_W = 24;
  localparam int unsigned DEF_DATA_W = 16;

  function automatic int unsigned mask_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sdram_arb_id_fifo.sv
// Port-ID FIFO tracking which requester issued each outstanding read.
// The head entry is visible combinationally so responses route in the same cycle.
module sdram_arb_id_fifo
  import sdram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic head_id,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  assign head_id = mem[rd_ptr];
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM controller command/response port between the CPU bridge
// (port 0) and the video DMA (port 1) with burst locking and anti-starvation.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned PENDING  = 4,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic                io_axiClk,
  input  logic                io_asyncReset,
  input  logic                io_p0_cmd_valid,
  output logic                io_p0_cmd_ready,
  input  logic                io_p0_cmd_write,
  input  logic [ADDR_W-1:0]   io_p0_cmd_address,
  input  logic [DATA_W-1:0]   io_p0_cmd_data,
  input  logic [DATA_W/8-1:0] io_p0_cmd_mask,
  input  logic                io_p0_cmd_last,
  output logic                io_p0_rsp_valid,
  output logic [DATA_W-1:0]   io_p0_rsp_data,
  input  logic                io_p1_cmd_valid,
  output logic                io_p1_cmd_ready,
  input  logic                io_p1_cmd_write,
  input  logic [ADDR_W-1:0]   io_p1_cmd_address,
  input  logic [DATA_W-1:0]   io_p1_cmd_data,
  input  logic [DATA_W/8-1:0] io_p1_cmd_mask,
  input  logic                io_p1_cmd_last,
  output logic                io_p1_rsp_valid,
  output logic [DATA_W-1:0]   io_p1_rsp_data,
  output logic                io_m_cmd_valid,
  input  logic                io_m_cmd_ready,
  output logic                io_m_cmd_write,
  output logic [ADDR_W-1:0]   io_m_cmd_address,
  output logic [DATA_W-1:0]   io_m_cmd_data,
  output logic [DATA_W/8-1:0] io_m_cmd_mask,
  input  logic                io_m_rsp_valid,
  input  logic [DATA_W-1:0]   io_m_rsp_data,
  output logic                io_error
);

  localparam int unsigned MASK_W = mask_w(DATA_W);
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  arb_state_t        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              sel;
  logic              sel_valid;
  logic              sel_write;
  logic              sel_last;
  logic              rd_blocked;
  logic              fire;
  logic              id_head;
  logic              id_full;
  logic              id_empty;
  logic              rsp_pop;
  logic [MASK_W-1:0] sel_mask;

  always_comb begin
    sel = PORT_CPU;
    unique case (state)
      ST_LOCK0: sel = PORT_CPU;
      ST_LOCK1: sel = PORT_VIDEO;
      default: begin
        if (io_p1_cmd_valid && !(wait_cnt == WAIT_MAX && io_p0_cmd_valid))
          sel = PORT_VIDEO;
      end
    endcase
  end

  assign sel_valid = (sel == PORT_VIDEO) ? io_p1_cmd_valid : io_p0_cmd_valid;
  assign sel_write = (sel == PORT_VIDEO) ? io_p1_cmd_write : io_p0_cmd_write;
  assign sel_last  = (sel == PORT_VIDEO) ? io_p1_cmd_last  : io_p0_cmd_last;
  assign sel_mask  = (sel == PORT_VIDEO) ? io_p1_cmd_mask  : io_p0_cmd_mask;

  // A pop in the same cycle frees the slot, so a full FIFO does not block then.
  assign rsp_pop    = io_m_rsp_valid && !id_empty;
  assign rd_blocked = !sel_write && id_full && !rsp_pop;

  assign io_m_cmd_valid   = sel_valid && !rd_blocked;
  assign io_m_cmd_write   = sel_write;
  assign io_m_cmd_address = (sel == PORT_VIDEO) ? io_p1_cmd_address : io_p0_cmd_address;
  assign io_m_cmd_data    = (sel == PORT_VIDEO) ? io_p1_cmd_data    : io_p0_cmd_data;
  assign io_m_cmd_mask    = sel_mask;

  assign fire            = io_m_cmd_valid && io_m_cmd_ready;
  assign io_p0_cmd_ready = fire && (sel == PORT_CPU);
  assign io_p1_cmd_ready = fire && (sel == PORT_VIDEO);

  assign io_p0_rsp_valid = rsp_pop && (id_head == PORT_CPU);
  assign io_p1_rsp_valid = rsp_pop && (id_head == PORT_VIDEO);
  assign io_p0_rsp_data  = io_m_rsp_data;
  assign io_p1_rsp_data  = io_m_rsp_data;

  sdram_arb_id_fifo #(
    .DEPTH (PENDING)
  ) u_id_fifo (
    .clk     (io_axiClk),
    .rst     (io_asyncReset),
    .push    (fire && !sel_write),
    .push_id (sel),
    .pop     (rsp_pop),
    .head_id (id_head),
    .full    (id_full),
    .empty   (id_empty)
  );

  always_ff @(posedge io_axiClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      state <= ST_IDLE;
    end else if (fire) begin
      if (sel_last)
        state <= ST_IDLE;
      else
        state <= (sel == PORT_VIDEO) ? ST_LOCK1 : ST_LOCK0;
    end
  end

  always_ff @(posedge io_axiClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      wait_cnt <= '0;
    end else if (io_p0_cmd_ready) begin
      wait_cnt <= '0;
    end else if (io_p0_cmd_valid && wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge io_axiClk or posedge io_asyncReset) begin
    if (io_asyncReset)
      io_error <= 1'b0;
    else if (io_m_rsp_valid && id_empty)
      io_error <= 1'b1;
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: reset-state vector table,
// directed corner sequences and randomized traffic against a queue-based model.
module tb_sdram_port_arbiter;

  localparam int ADDR_W   = 24;
  localparam int DATA_W   = 16;
  localparam int PENDING  = 4;
  localparam int MAX_WAIT = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              p0_valid, p0_ready, p0_write, p0_last, p0_rsp_valid;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_data, p0_rsp_data;
  logic [1:0]        p0_mask;
  logic              p1_valid, p1_ready, p1_write, p1_last, p1_rsp_valid;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_data, p1_rsp_data;
  logic [1:0]        p1_mask;
  logic              m_valid, m_ready, m_write, m_rsp_valid, error;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data, m_rsp_data;
  logic [1:0]        m_mask;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: burst owner (-1 = none), outstanding read IDs, wait count.
  int owner;
  bit idq[$];
  int wcnt;
  bit merr;

  bit obs_r0, obs_r1, obs_mv, obs_rsp0, obs_rsp1;

  sdram_port_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .PENDING  (PENDING),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .io_axiClk         (clk),
    .io_asyncReset     (rst),
    .io_p0_cmd_valid   (p0_valid),
    .io_p0_cmd_ready   (p0_ready),
    .io_p0_cmd_write   (p0_write),
    .io_p0_cmd_address (p0_addr),
    .io_p0_cmd_data    (p0_data),
    .io_p0_cmd_mask    (p0_mask),
    .io_p0_cmd_last    (p0_last),
    .io_p0_rsp_valid   (p0_rsp_valid),
    .io_p0_rsp_data    (p0_rsp_data),
    .io_p1_cmd_valid   (p1_valid),
    .io_p1_cmd_ready   (p1_ready),
    .io_p1_cmd_write   (p1_write),
    .io_p1_cmd_address (p1_addr),
    .io_p1_cmd_data    (p1_data),
    .io_p1_cmd_mask    (p1_mask),
    .io_p1_cmd_last    (p1_last),
    .io_p1_rsp_valid   (p1_rsp_valid),
    .io_p1_rsp_data    (p1_rsp_data),
    .io_m_cmd_valid    (m_valid),
    .io_m_cmd_ready    (m_ready),
    .io_m_cmd_write    (m_write),
    .io_m_cmd_address  (m_addr),
    .io_m_cmd_data     (m_data),
    .io_m_cmd_mask     (m_mask),
    .io_m_rsp_valid    (m_rsp_valid),
    .io_m_rsp_data     (m_rsp_data),
    .io_error          (error)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    p0_valid = 0; p0_write = 0; p0_last = 1; p0_addr = '0; p0_data = '0; p0_mask = '0;
    p1_valid = 0; p1_write = 0; p1_last = 1; p1_addr = '0; p1_data = '0; p1_mask = '0;
    m_ready = 0; m_rsp_valid = 0; m_rsp_data = '0;
  endtask

  task automatic model_reset();
    owner = -1;
    idq.delete();
    wcnt = 0;
    merr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(posedge clk); #1;
    rst = 1;
    #2;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_p0_ready", p0_ready, 0);
    chk("rst_p1_ready", p1_ready, 0);
    chk("rst_error", error, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 0;
  endtask

  // One clock cycle: compare DUT outputs against the model, then advance both.
  task automatic cycle();
    int sel;
    bit sv, sw, sl, pop_ok, exp_mv, fire;
    logic [ADDR_W-1:0] sa;
    logic [DATA_W-1:0] sd;
    logic [1:0]        sm;
    #2;
    if (owner >= 0) sel = owner;
    else sel = (p1_valid && !(wcnt == MAX_WAIT && p0_valid)) ? 1 : 0;
    sv = sel ? p1_valid : p0_valid;
    sw = sel ? p1_write : p0_write;
    sl = sel ? p1_last  : p0_last;
    sa = sel ? p1_addr  : p0_addr;
    sd = sel ? p1_data  : p0_data;
    sm = sel ? p1_mask  : p0_mask;
    pop_ok = m_rsp_valid && idq.size() > 0;
    exp_mv = sv && (sw || idq.size() < PENDING || pop_ok);
    fire = exp_mv && m_ready;

    obs_r0 = p0_ready; obs_r1 = p1_ready; obs_mv = m_valid;
    obs_rsp0 = p0_rsp_valid; obs_rsp1 = p1_rsp_valid;

    chk("m_cmd_valid", m_valid, exp_mv);
    chk("p0_cmd_ready", p0_ready, fire && sel == 0);
    chk("p1_cmd_ready", p1_ready, fire && sel == 1);
    chk("m_cmd_write", m_write, sw);
    chk("m_cmd_address", m_addr, sa);
    chk("m_cmd_data", m_data, sd);
    chk("m_cmd_mask", m_mask, sm);
    chk("p0_rsp_valid", p0_rsp_valid, pop_ok && idq[0] == 0);
    chk("p1_rsp_valid", p1_rsp_valid, pop_ok && idq[0] == 1);
    if (pop_ok) chk("rsp_data", idq[0] ? p1_rsp_data : p0_rsp_data, m_rsp_data);
    chk("error", error, merr);

    if (m_rsp_valid && idq.size() == 0) merr = 1;
    if (pop_ok) void'(idq.pop_front());
    if (fire && !sw) idq.push_back(sel[0]);
    if (fire && sel == 0) wcnt = 0;
    else if (p0_valid && wcnt < MAX_WAIT) wcnt++;
    if (fire) owner = sl ? -1 : sel;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit p0v, p0w, p0l, p1v, p1w, p1l, mr, rspv;
    bit e_mv, e_r0, e_r1, e_sel, e_err;
  } vec_t;

  vec_t vec [8];

  initial begin
    idle_inputs();
    model_reset();

    // Single-cycle behaviour from the reset state (empty FIFO, wait count 0).
    //           p0v p0w p0l p1v p1w p1l mr rsp  mv r0 r1 sel err
    vec[0] = '{0,  0,  1,  0,  0,  1,  1, 0,   0, 0, 0, 0,  0};
    vec[1] = '{1,  1,  1,  0,  0,  1,  1, 0,   1, 1, 0, 0,  0};
    vec[2] = '{0,  0,  1,  1,  0,  1,  1, 0,   1, 0, 1, 1,  0};
    vec[3] = '{1,  1,  1,  1,  0,  1,  1, 0,   1, 0, 1, 1,  0};
    vec[4] = '{1,  0,  1,  1,  1,  1,  0, 0,   1, 0, 0, 1,  0};
    vec[5] = '{1,  0,  0,  0,  0,  1,  0, 0,   1, 0, 0, 0,  0};
    vec[6] = '{0,  0,  1,  0,  0,  1,  1, 1,   0, 0, 0, 0,  1};
    vec[7] = '{1,  1,  1,  0,  0,  1,  1, 1,   1, 1, 0, 0,  1};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      p0_valid = vec[i].p0v; p0_write = vec[i].p0w; p0_last = vec[i].p0l; p0_addr = 24'h111111;
      p1_valid = vec[i].p1v; p1_write = vec[i].p1w; p1_last = vec[i].p1l; p1_addr = 24'h222222;
      m_ready = vec[i].mr; m_rsp_valid = vec[i].rspv;
      #2;
      chk("vec_m_valid", m_valid, vec[i].e_mv);
      chk("vec_p0_ready", p0_ready, vec[i].e_r0);
      chk("vec_p1_ready", p1_ready, vec[i].e_r1);
      chk("vec_address", m_addr, vec[i].e_sel ? 24'h222222 : 24'h111111);
      chk("vec_rsp_valid", {p0_rsp_valid, p1_rsp_valid}, 2'b00);
      @(posedge clk); #1;
      chk("vec_error", error, vec[i].e_err);
    end

    // Port 1 reads only, responses return on port 1 in order.
    do_reset();
    begin
      int fires = 0;
      m_ready = 1; p1_valid = 1; p1_write = 0; p1_last = 1;
      for (int i = 0; i < 4; i++) begin
        p1_addr = 24'h000100 + 24'(i);
        cycle();
        if (obs_r1) fires++;
      end
      chk("t1_fires", fires, 4);
      p1_valid = 0;
      for (int i = 0; i < 4; i++) begin
        m_rsp_valid = 1; m_rsp_data = 16'h00A0 + 16'(i);
        cycle();
        chk("t1_rsp_route", {obs_rsp0, obs_rsp1}, 2'b01);
      end
      m_rsp_valid = 0;
    end

    // Both ports streaming single-beat writes: port 0 breaks through at wait 16.
    do_reset();
    m_ready = 1;
    p0_valid = 1; p0_write = 1; p0_last = 1; p0_addr = 24'h00AAAA;
    p1_valid = 1; p1_write = 1; p1_last = 1; p1_addr = 24'h00BBBB;
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("t2_p0_fire", obs_r0, i == 16);
      chk("t2_p1_fire", obs_r1, i != 16);
    end

    // Port 0 four-beat burst holds off port 1 until its last beat.
    do_reset();
    m_ready = 1;
    p0_valid = 1; p0_write = 1; p0_last = 0; p0_addr = 24'h000010;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin p1_valid = 1; p1_write = 1; p1_last = 1; p1_addr = 24'h000020; end
      if (i == 3) p0_last = 1;
      if (i == 4) p0_valid = 0;
      cycle();
      chk("t3_p0_fire", obs_r0, i < 4);
      chk("t3_p1_fire", obs_r1, i == 4);
    end
    p1_valid = 0;

    // Read gating at PENDING outstanding, released by a same-cycle response.
    do_reset();
    m_ready = 1; p0_valid = 1; p0_write = 0; p0_last = 1; p0_addr = 24'h000300;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t4_fire", obs_r0, i < 4);
      chk("t4_m_valid", obs_mv, i < 4);
    end
    m_rsp_valid = 1; m_rsp_data = 16'h5555;
    cycle();
    chk("t4_unblock_fire", obs_r0, 1);
    chk("t4_rsp_p0", obs_rsp0, 1);
    p0_valid = 0;
    for (int i = 0; i < 4; i++) begin
      m_rsp_data = 16'h6000 + 16'(i);
      cycle();
    end
    m_rsp_valid = 0;

    // Interleaved reads route 0,1,0; then a stray response sets the sticky error.
    do_reset();
    m_ready = 1; p0_write = 0; p1_write = 0; p0_last = 1; p1_last = 1;
    p0_valid = 1; p0_addr = 24'h000400; cycle();
    p0_valid = 0; p1_valid = 1; p1_addr = 24'h000500; cycle();
    p1_valid = 0; p0_valid = 1; p0_addr = 24'h000401; cycle();
    p0_valid = 0;
    for (int i = 0; i < 3; i++) begin
      m_rsp_valid = 1; m_rsp_data = 16'h0C00 + 16'(i);
      cycle();
      chk("t5_route", {obs_rsp0, obs_rsp1}, (i == 1) ? 2'b01 : 2'b10);
    end
    m_rsp_data = 16'hDEAD;
    cycle();
    chk("t5_stray_rsp", {obs_rsp0, obs_rsp1}, 2'b00);
    m_rsp_valid = 0;
    chk("t5_error_set", error, 1);
    for (int i = 0; i < 3; i++) cycle();
    chk("t5_error_sticky", error, 1);

    // Reset in the middle of a port 1 burst with two reads outstanding.
    p1_valid = 1; p1_write = 0; p1_last = 0; p1_addr = 24'h000600;
    cycle();
    cycle();
    idle_inputs();
    rst = 1;
    #2;
    chk("t6_rst_error", error, 0);
    chk("t6_rst_m_valid", m_valid, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    m_rsp_valid = 1; m_rsp_data = 16'hBEEF;
    cycle();
    chk("t6_fifo_empty_no_rsp", {obs_rsp0, obs_rsp1}, 2'b00);
    chk("t6_fifo_empty_error", error, 1);
    m_rsp_valid = 0;
    m_ready = 1; p0_valid = 1; p0_write = 0; p0_last = 1; p0_addr = 24'h000700;
    cycle();
    chk("t6_p0_granted", obs_r0, 1);
    p0_valid = 0;

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      p0_valid = ($urandom_range(0, 99) < 60);
      p0_write = $urandom_range(0, 1);
      p0_last  = ($urandom_range(0, 3) != 0);
      p0_addr  = ADDR_W'($urandom);
      p0_data  = DATA_W'($urandom);
      p0_mask  = 2'($urandom);
      p1_valid = ($urandom_range(0, 99) < 60);
      p1_write = $urandom_range(0, 1);
      p1_last  = ($urandom_range(0, 3) != 0);
      p1_addr  = ADDR_W'($urandom);
      p1_data  = DATA_W'($urandom);
      p1_mask  = 2'($urandom);
      m_ready  = ($urandom_range(0, 99) < 75);
      m_rsp_valid = (idq.size() > 0) ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 2);
      m_rsp_data  = DATA_W'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
